// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU writeback (A) and the load writeback (B), with a registered write.
module rf_wr_arbiter #(
    parameter int PW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hold,
    input  logic          a_valid,
    input  logic [PW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [PW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_wr_en,
    output logic [PW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_dat_in,
    output logic          last_grant,
    output logic [7:0]    conflict_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic          rf_wr_en_q, rf_wr_en_d;
    logic [PW-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DW-1:0] rf_dat_in_q, rf_dat_in_d;
    logic          last_grant_q, last_grant_d;
    logic [7:0]    conflict_cnt_q, conflict_cnt_d;

    logic          grant_a, grant_b;
    logic [PW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        grant_a = reset_n & ~hold & a_valid & (~b_valid | last_grant_q);
        grant_b = reset_n & ~hold & b_valid & (~a_valid | ~last_grant_q);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        sel_addr       = grant_b ? b_addr : a_addr;
        sel_data       = grant_b ? b_data : a_data;
        rf_wr_en_d     = 1'b0;
        rf_wr_addr_d   = rf_wr_addr_q;
        rf_dat_in_d    = rf_dat_in_q;
        last_grant_d   = last_grant_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant_a || grant_b) begin
            // r0 writes are still accepted and loaded; only the enable is suppressed.
            rf_wr_en_d   = (sel_addr != '0);
            rf_wr_addr_d = sel_addr;
            rf_dat_in_d  = sel_data;
            last_grant_d = grant_b;
        end

        if (a_valid && b_valid && !hold)
            conflict_cnt_d = sat_inc(conflict_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en_q     <= 1'b0;
            rf_wr_addr_q   <= '0;
            rf_dat_in_q    <= '0;
            last_grant_q   <= 1'b1;
            conflict_cnt_q <= 8'h00;
        end else begin
            rf_wr_en_q     <= rf_wr_en_d;
            rf_wr_addr_q   <= rf_wr_addr_d;
            rf_dat_in_q    <= rf_dat_in_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign rf_wr_en     = rf_wr_en_q;
    assign rf_wr_addr   = rf_wr_addr_q;
    assign rf_dat_in    = rf_dat_in_q;
    assign last_grant   = last_grant_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of the arbitration and register-file write rules.
module tb_rf_wr_arbiter;

    localparam int PW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hold = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [PW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, rf_wr_en, last_grant;
    logic [PW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_dat_in;
    logic [7:0]    conflict_cnt;

    rf_wr_arbiter #(.PW(PW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_lg;
    int          m_cnt;
    bit          m_en;
    logic [PW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_rf  [2**PW];
    logic [DW-1:0] dut_rf[2**PW];
    bit          ga_l, gb_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lg = 1'b1; m_cnt = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // One clock: readies checked mid-cycle, registered outputs just after the edge.
    task automatic cycle();
        bit ga, gb, av, bv, hd;
        logic [PW-1:0] aa, ba;
        logic [DW-1:0] ad, bd;
        @(negedge clk);
        av = a_valid; bv = b_valid; hd = hold;
        aa = a_addr; ba = b_addr; ad = a_data; bd = b_data;
        ga = 0; gb = 0;
        if (!hd) begin
            if (av && bv) begin
                if (m_lg) ga = 1; else gb = 1;
            end else begin
                ga = av; gb = bv;
            end
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        if (rf_wr_en) dut_rf[rf_wr_addr] = rf_dat_in;
        @(posedge clk);
        if (m_en) m_rf[m_addr] = m_data;
        if (av && bv && !hd && m_cnt < 255) m_cnt++;
        if (ga) begin
            m_en = (aa != 0); m_addr = aa; m_data = ad; m_lg = 0;
        end else if (gb) begin
            m_en = (ba != 0); m_addr = ba; m_data = bd; m_lg = 1;
        end else begin
            m_en = 0;
        end
        ga_l = ga; gb_l = gb;
        #1;
        chk("rf_wr_en", rf_wr_en, m_en);
        chk("rf_wr_addr", rf_wr_addr, m_addr);
        chk("rf_dat_in", rf_dat_in, m_data);
        chk("last_grant", last_grant, m_lg);
        chk("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    // Asynchronous reset pulse taken away from the clock edge.
    task automatic do_reset(input string tag);
        #3;
        reset_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk({tag, "_en"}, rf_wr_en, 0);
        chk({tag, "_addr"}, rf_wr_addr, 0);
        chk({tag, "_data"}, rf_dat_in, 0);
        chk({tag, "_lg"}, last_grant, 1);
        chk({tag, "_cnt"}, conflict_cnt, 0);
        chk({tag, "_ardy"}, a_ready, 0);
        chk({tag, "_brdy"}, b_ready, 0);
        model_reset();
        a_valid = 0; b_valid = 0; hold = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a_pend, b_pend;
        int cnt_before;
        for (int i = 0; i < 2**PW; i++) begin m_rf[i] = '0; dut_rf[i] = '0; end
        model_reset();

        @(posedge clk); #1;
        do_reset("rst0");

        // 1: A alone after reset
        a_valid = 1; a_addr = 3; a_data = 8'h5A;
        cycle();
        chk("t1_grant_a", ga_l, 1);
        chk("t1_en", rf_wr_en, 1);
        chk("t1_addr", rf_wr_addr, 3);
        chk("t1_data", rf_dat_in, 8'h5A);
        chk("t1_lg", last_grant, 0);
        a_valid = 0;

        // 2: both valid for four cycles from reset -> A,B,A,B
        do_reset("rst2");
        a_valid = 1; a_addr = 1; a_data = 8'h10;
        b_valid = 1; b_addr = 2; b_data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_lg", last_grant, i % 2);
            chk("t2_data", rf_dat_in, (i % 2) ? 8'h20 : 8'h10);
        end
        chk("t2_cnt", conflict_cnt, 4);

        // 3: B writes r0
        a_valid = 0; b_addr = 0; b_data = 8'hFF;
        cycle();
        chk("t3_grant_b", gb_l, 1);
        chk("t3_en", rf_wr_en, 0);
        chk("t3_addr", rf_wr_addr, 0);
        chk("t3_data", rf_dat_in, 8'hFF);
        b_valid = 0;
        cycle();

        // 4: hold with both valid
        cnt_before = conflict_cnt;
        hold = 1; a_valid = 1; b_valid = 1; a_addr = 4; b_addr = 6;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_en", rf_wr_en, 0);
        end
        chk("t4_cnt", conflict_cnt, cnt_before);
        hold = 0;
        cycle();
        chk("t4_resume_a", ga_l, 1);
        chk("t4_lg", last_grant, 0);

        // 5: long contention saturates the counter, then async reset mid-run
        for (int i = 0; i < 300; i++) begin
            a_data = 8'($urandom); b_data = 8'($urandom);
            cycle();
        end
        chk("t5_sat", conflict_cnt, 8'hFF);
        cycle();
        chk("t5_sat_hold", conflict_cnt, 8'hFF);
        do_reset("rst5");

        // 6: same address contention, loser's data lands last
        a_valid = 1; a_addr = 5; a_data = 8'h11;
        b_valid = 1; b_addr = 5; b_data = 8'h22;
        cycle();
        chk("t6_first", rf_dat_in, 8'h11);
        a_valid = 0;
        cycle();
        chk("t6_second", rf_dat_in, 8'h22);
        b_valid = 0;
        cycle();
        chk("t6_rf", dut_rf[5], 8'h22);
        chk("t6_rf_model", dut_rf[5], m_rf[5]);

        // Randomized traffic; requesters hold their request until ready
        a_pend = 0; b_pend = 0;
        for (int i = 0; i < 600; i++) begin
            if (!a_pend && ($urandom_range(3) != 0)) begin
                a_pend = 1; a_addr = PW'($urandom); a_data = 8'($urandom);
            end
            if (!b_pend && ($urandom_range(3) != 0)) begin
                b_pend = 1; b_addr = PW'($urandom); b_data = 8'($urandom);
            end
            a_valid = a_pend; b_valid = b_pend;
            hold = ($urandom_range(7) == 0);
            cycle();
            if (ga_l) a_pend = 0;
            if (gb_l) b_pend = 0;
        end
        a_valid = 0; b_valid = 0; hold = 0;
        cycle();
        cycle();
        for (int i = 1; i < 2**PW; i++) chk("rand_rf", dut_rf[i], m_rf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
